// File: rtl/fractcam_block.sv
// SRL32-style ternary CAM block: per-(slice, entry) 32-bit lookup columns, shifted-in update, lowest-index priority match.
// Optional FRACTCAM_MULTI_MATCH_EN adds the registered match_vec / match_count outputs.
module fractcam_block #(
    parameter int KEY_WIDTH  = 160,
    parameter int ENTRIES    = 32,
    parameter int ADDR_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  sk,
    input  logic                  sk_valid,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_value,
    input  logic [KEY_WIDTH-1:0]  wr_mask,
    input  logic                  wr_delete,
    output logic                  wr_done,
    output logic                  result_valid,
    output logic                  match,
`ifdef FRACTCAM_MULTI_MATCH_EN
    output logic [ENTRIES-1:0]    match_vec,
    output logic [ADDR_WIDTH:0]   match_count,
`endif
    output logic [ADDR_WIDTH-1:0] match_addr
);

    localparam int SLICES = (KEY_WIDTH + 4) / 5;
    localparam int PAD_W  = SLICES * 5;
    localparam logic [ADDR_WIDTH:0] ENTRY_LIMIT = (ADDR_WIDTH+1)'(ENTRIES);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic [4:0]              cnt;
    logic [ADDR_WIDTH-1:0]   upd_addr;
    logic [PAD_W-1:0]        upd_value;
    logic [PAD_W-1:0]        upd_mask;
    logic                    upd_delete;
    logic                    upd_in_range;
    logic                    req_in_range;
    logic [PAD_W-1:0]        value_pad;
    logic [PAD_W-1:0]        mask_pad;
    logic [PAD_W-1:0]        sk_pad;
    logic [SLICES-1:0]       shift_bits;
    logic [ENTRIES-1:0]      entry_valid;
    logic [31:0]             column [SLICES][ENTRIES];

    logic                    s1_valid;
    logic [PAD_W-1:0]        s1_key;
    logic [ENTRIES-1:0]      hit_vec;
    logic                    s2_valid;
    logic [ENTRIES-1:0]      s2_vec;
    logic [ADDR_WIDTH-1:0]   enc_addr;
    logic                    any_hit;
`ifdef FRACTCAM_MULTI_MATCH_EN
    logic [ADDR_WIDTH:0]     hit_count;
`endif

    // Padding bits are zero in key, value and mask, so they always agree.
    always_comb begin
        value_pad = '0;
        mask_pad  = '0;
        sk_pad    = '0;
        value_pad[KEY_WIDTH-1:0] = wr_value;
        mask_pad[KEY_WIDTH-1:0]  = wr_mask;
        sk_pad[KEY_WIDTH-1:0]    = sk;
    end

    assign req_in_range = ({1'b0, wr_addr} < ENTRY_LIMIT);
    assign upd_in_range = ({1'b0, upd_addr} < ENTRY_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        wr_done    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 5'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                wr_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            upd_addr   <= wr_addr;
            upd_value  <= value_pad;
            upd_mask   <= mask_pad;
            upd_delete <= wr_delete;
            cnt        <= 5'd31;
        end else if (state == SHIFT) begin
            cnt <= cnt - 5'd1;
        end
    end

    // Bit c of each column ends up holding "slice value c matches this rule".
    always_comb begin
        shift_bits = '0;
        for (int s = 0; s < SLICES; s++) begin
            shift_bits[s] = ~upd_delete &
                (((cnt ^ upd_value[s*5 +: 5]) & ~upd_mask[s*5 +: 5]) == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid <= '0;
        end else if (accept && req_in_range) begin
            entry_valid[wr_addr] <= 1'b0;
        end else if (state == SHIFT && cnt == 5'd0 && upd_in_range) begin
            entry_valid[upd_addr] <= ~upd_delete;
        end
    end

    // Column storage has no reset, like the SRL primitives it models; valid bits gate it.
    always_ff @(posedge clk) begin
        if (!reset && state == SHIFT && upd_in_range) begin
            for (int s = 0; s < SLICES; s++) begin
                column[s][upd_addr] <= {column[s][upd_addr][30:0], shift_bits[s]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sk_valid;
            s1_key   <= sk_pad;
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            hit_vec[e] = entry_valid[e];
            for (int s = 0; s < SLICES; s++) begin
                hit_vec[e] = hit_vec[e] & column[s][e][s1_key[s*5 +: 5]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_vec   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_vec   <= hit_vec;
        end
    end

    // Scan downward so the lowest matching index wins.
    always_comb begin
        enc_addr = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (s2_vec[e]) begin
                enc_addr = e[ADDR_WIDTH-1:0];
            end
        end
    end

    assign any_hit = |s2_vec;

`ifdef FRACTCAM_MULTI_MATCH_EN
    always_comb begin
        hit_count = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            hit_count = hit_count + {{ADDR_WIDTH{1'b0}}, s2_vec[e]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid <= 1'b0;
            match        <= 1'b0;
            match_addr   <= '0;
`ifdef FRACTCAM_MULTI_MATCH_EN
            match_vec    <= '0;
            match_count  <= '0;
`endif
        end else begin
            result_valid <= s2_valid;
            match        <= s2_valid & any_hit;
            match_addr   <= s2_valid ? enc_addr : '0;
`ifdef FRACTCAM_MULTI_MATCH_EN
            match_vec    <= s2_valid ? s2_vec : '0;
            match_count  <= s2_valid ? hit_count : '0;
`endif
        end
    end

endmodule

// File: doc/fractcam_block.md
Name: fractcam_block

Overview:
- Parametrised SRL32-style ternary CAM block: successor to the fixed 1024x160 FRACTCAM top.
- Key split into 5-bit slices. Each (slice, entry) pair holds a 32-bit lookup column. An entry matches when its columns for all slices are 1 at the slice value.
- Adds an explicit write handshake, per-entry valid bits, delete, and a pipelined lowest-index priority encoder producing a match address.
- Instantiated per block under the search-key distributor; results are OR/priority-merged by the parent.

Parameters:
KEY_WIDTH, 160, search key width in bits; slices S = ceil(KEY_WIDTH/5), top slice zero-padded in both key and rule.
ENTRIES, 32, number of rules, 1..1024.
ADDR_WIDTH, $clog2(ENTRIES) (min 1), width of entry addresses.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sk  in  KEY_WIDTH  search key
sk_valid  in  1  search request
wr_valid  in  1  update request
wr_ready  out  1  update accepted when wr_valid&wr_ready
wr_addr  in  ADDR_WIDTH  entry to update
wr_value  in  KEY_WIDTH  rule value
wr_mask  in  KEY_WIDTH  rule mask, 1 = don't care
wr_delete  in  1  1 = invalidate entry instead of writing
wr_done  out  1  one-cycle pulse when update complete
result_valid  out  1  search result strobe
match  out  1  any valid entry matched
match_addr  out  ADDR_WIDTH  lowest matching index, 0 when match=0

Behaviour:
- Reset:
  - wr_ready=1, wr_done=0, result_valid=0, match=0, match_addr=0.
  - All entry valid bits = 0; FSM to IDLE; search pipeline flushed.
  - Column storage is not reset (as SRL hardware); valid bits gate it.
- FSM states:
  - IDLE: wr_ready=1.
  - SHIFT: wr_ready=0, 5-bit counter c.
  - DONE: wr_ready=0, wr_done=1.
- Acceptance edge (IDLE, wr_valid=1):
  - Latch addr/value/mask/delete.
  - Clear valid[wr_addr]; c=31; state→SHIFT.
- SHIFT, each cycle:
  - For every slice s, shift bit b_s = (((c ^ value_s) & ~mask_s) == 0) into bit 0 of column[s][addr]; existing bits move up by one.
  - c decrements.
  - After the c=0 cycle (32 cycles total), state→DONE.
  - On that same edge, valid[addr] = ~delete.
  - After 32 shifts, column bit k = match for slice value k.
- DONE: one cycle, then IDLE. Next request can be accepted 34 cycles after the prior acceptance.
- Delete still runs the 32 shift cycles, shifting zeros.
- wr_addr ≥ ENTRIES (non-power-of-2 depth): full sequence runs, wr_done pulses, no storage or valid change.
- Search pipeline, latency 2:
  - Stage 1 registers sk/sk_valid.
  - Stage 2 registers match_vec[e] = valid[e] & AND_s column[s][e][sk_s].
  - Output stage registers the priority encode.
  - Result for sk presented at edge T appears with result_valid in the cycle after edge T+2.
  - One search per cycle; no backpressure.
- Searches concurrent with an update:
  - The entry under update never matches; its valid bit is 0 from acceptance to end of SHIFT.
  - All other entries are unaffected.
- result_valid=0 → match, match_addr held at 0.
- Reset mid-update: abort immediately, no wr_done, valid bits all cleared, in-flight searches dropped.
- wr_valid with wr_ready=0: ignored; the requester must hold it.

Optional Feature:
- FRACTCAM_MULTI_MATCH_EN defined:
  - Adds output match_vec [ENTRIES-1:0], registered and aligned with result_valid; zero when result_valid=0.
  - Adds output match_count [ADDR_WIDTH:0] = popcount of match_vec, same timing.
- Undefined: both ports absent; only the priority result exists.

Test Plan:
1. Release reset, search sk=0,3,20,30,17 back-to-back with sk_valid=1 → five result_valid pulses starting 2 cycles later, all match=0.
2. Write entry 3 value=17 mask=0 → wr_ready low 33 cycles, wr_done at cycle 33 after acceptance. Then search 0,3,20,30,17 → only 17 gives match=1, match_addr=3.
3. Write entry 5 value=16 mask=1 → search 17 gives addr 3 (priority); search 16 gives addr 5; search 18 gives match=0.
4. Delete entry 3 → search 17 gives addr 5. Write entry 31 mask all-ones → search 160'hFFFF gives addr 31.
5. Issue search 16 every cycle while rewriting entry 5 → match=0 for searches evaluated during SHIFT, match=1 addr=5 from wr_done onward. Meanwhile entry 31 keeps matching 160'hFFFF throughout.
6. Accept write to entry 7, assert reset at SHIFT cycle 10 → next cycle wr_ready=1, wr_done never pulses, every search misses. With FRACTCAM_MULTI_MATCH_EN defined, scenario 4 setup plus search 16 → match_vec bits 5 and 31 set, match_count=2.
